// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared constants and types for the instruction-fetch stage:
//               datapath width, default reset PC, canonical NOP encoding, the
//               fetch-queue entry layout and the fetch control state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0 -- issued in place of a real word for misaligned targets
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
    logic            misalign;
  } fetch_entry_t;

  // RUN    : normal sequential fetching
  // MARKER : misaligned redirect taken; fault marker is enqueued this cycle
  // HALT   : marker delivered or pending in queue; no fetch until next redirect
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MARKER = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : Generic ripple-free (behavioural) adder with carry in/out.
// Ports       : a, b  - operands (WIDTH)
//               cin   - carry in
//               sum   - a + b + cin, truncated to WIDTH
//               cout  - carry out of the top bit
// Revision    : 1.0 - initial release
// ============================================================================
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full_sum;

  assign full_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign {cout, sum} = full_sum;

endmodule
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry queue of fetch entries between the fetch stage and
//               decode. Head entry is presented combinationally. Flush empties
//               the queue and takes priority over push and pop.
// Ports       : clk, rst_n        - clock, async active-low reset
//               push, push_data   - enqueue an entry (caller guarantees room)
//               pop               - dequeue head (ignored when empty)
//               flush             - discard all entries
//               head              - oldest entry
//               occ               - number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   occ
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_pop;

  assign do_pop = pop & (count != 2'd0);
  assign head   = mem[rd_ptr];
  assign occ    = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and instruction fetch stage. Issues one read
//               per cycle to a synchronous instruction memory, buffers the
//               returned words in a 2-entry queue and hands them to decode
//               over a valid/ready handshake. Redirects from execute flush the
//               queue and discard any in-flight response. A misaligned
//               redirect target produces a single fault-marker entry and
//               halts fetching until the next redirect.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               imem_en, imem_addr, imem_rdata - instruction memory port
//               redirect_valid, redirect_pc    - PC change request from execute
//               if_valid, if_ready             - handshake to decode
//               if_pc, if_pc_plus4, if_instr   - head entry contents
//               if_misalign                    - head is a misalign fault marker
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr,
  output logic            if_misalign
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_pc_plus4;
  logic            inflight;
  logic            pc_carry_unused;

  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic [1:0]      occ;
  logic            push;
  logic            pop;
  logic            handshake;
  logic            room;
  logic            redirect_misaligned;
  logic            resp_push;
  logic            marker_push;

  // --------------------------------------------------------------------------
  // Sequential PC increment; wraps modulo 2^XLEN, carry discarded
  // --------------------------------------------------------------------------
  adder #(
    .WIDTH (XLEN)
  ) u_pc_adder (
    .a    (pc),
    .b    (XLEN'(4)),
    .cin  (1'b0),
    .sum  (pc_plus4),
    .cout (pc_carry_unused)
  );

  // --------------------------------------------------------------------------
  // Issue control
  // --------------------------------------------------------------------------
  assign handshake           = if_valid & if_ready;
  assign redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

  // Only issue when the queue can absorb every outstanding response, counting
  // the slot freed by a pop in this same cycle.
  assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, handshake});

  assign imem_en   = rst_n & ~redirect_valid & (state == ST_RUN) & room;
  assign imem_addr = pc;

  // --------------------------------------------------------------------------
  // Queue push/pop. A redirect kills the in-flight response and any marker,
  // and a pop in the redirect cycle is meaningless since the queue flushes.
  // --------------------------------------------------------------------------
  assign resp_push   = inflight & ~redirect_valid;
  assign marker_push = (state == ST_MARKER) & ~redirect_valid;
  assign push        = resp_push | marker_push;
  assign pop         = handshake & ~redirect_valid;

  always_comb begin
    push_data = '0;
    if (marker_push) begin
      push_data.pc       = pc;
      push_data.pc_plus4 = pc_plus4;
      push_data.instr    = NOP_INSTR;
      push_data.misalign = 1'b1;
    end else begin
      push_data.pc       = req_pc;
      push_data.pc_plus4 = req_pc_plus4;
      push_data.instr    = imem_rdata;
      push_data.misalign = 1'b0;
    end
  end

  fetch_fifo u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .occ       (occ)
  );

  // --------------------------------------------------------------------------
  // PC / request tracking / fetch control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      req_pc       <= '0;
      req_pc_plus4 <= '0;
      inflight     <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      state    <= redirect_misaligned ? ST_MARKER : ST_RUN;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc           <= pc_plus4;
        req_pc       <= pc;
        req_pc_plus4 <= pc_plus4;
      end
      case (state)
        ST_RUN:    state <= ST_RUN;
        ST_MARKER: state <= ST_HALT;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Decode-facing outputs
  // --------------------------------------------------------------------------
  assign if_valid    = (occ != 2'd0);
  assign if_pc       = head.pc;
  assign if_pc_plus4 = head.pc_plus4;
  assign if_instr    = head.instr;
  assign if_misalign = head.misalign & if_valid;

endmodule
`default_nettype wire
